mul_i16_acc: RTL and testbench

- Accumulator stage directly downstream of the 16-bit Booth multiplier.
- Consumes the multiplier's product stream (product valid strobe plus 32-bit product) and sums a programmed burst of N products into a wide accumulator, with optional saturation.
- Presents the final sum on a valid/ready result interface.
- The multiplier has no backpressure, so this block reports busy/ready and flags any product it cannot take.

---
 rtl/mul_i16_acc.sv | 150 +++++++++++++++
 tb/tb_mul_i16_acc.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_i16_acc.sv
// Burst accumulator behind the 16-bit Booth multiplier: sums a programmed
// number of products into a wide accumulator, with optional saturation.
module mul_i16_acc #(
  parameter int PROD_WIDTH = 32,
  parameter int ACC_WIDTH  = 40,
  parameter int CNT_WIDTH  = 8,
  parameter bit SAT_EN     = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [CNT_WIDTH-1:0]  len_i,
  input  logic                  signed_i,
  input  logic                  prod_vld_i,
  input  logic [PROD_WIDTH-1:0] prod_i,
  output logic                  acc_rdy_o,
  output logic                  res_vld_o,
  input  logic                  res_rdy_i,
  output logic [ACC_WIDTH-1:0]  res_o,
  output logic                  ovf_o,
  output logic                  drop_err_o,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   sgn_q, sgn_d;
  logic                   ovf_q, ovf_d;
  logic                   drop_q, drop_d;

  logic                   add_sgn;
  logic [ACC_WIDTH-1:0]   add_base;
  logic [ACC_WIDTH:0]     base_ext;
  logic [ACC_WIDTH:0]     prod_ext;
  logic [ACC_WIDTH:0]     sum;
  logic                   sum_ovf;
  logic [ACC_WIDTH-1:0]   sum_res;

  // The first product of a burst may arrive with start_i, so in IDLE the
  // adder starts from zero and uses the incoming signedness.
  always_comb begin
    add_sgn  = (state_q == S_IDLE) ? signed_i : sgn_q;
    add_base = (state_q == S_IDLE) ? '0 : acc_q;
    base_ext = {add_sgn & add_base[ACC_WIDTH-1], add_base};
    prod_ext = {{(ACC_WIDTH+1-PROD_WIDTH){add_sgn & prod_i[PROD_WIDTH-1]}}, prod_i};
    sum      = base_ext + prod_ext;
    if (add_sgn) begin
      sum_ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    end else begin
      sum_ovf = sum[ACC_WIDTH];
    end
    sum_res = sum[ACC_WIDTH-1:0];
    if (SAT_EN && sum_ovf) begin
      if (add_sgn) begin
        sum_res = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                 : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else begin
        sum_res = '1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    ovf_d   = ovf_q;
    drop_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          sgn_d = signed_i;
          ovf_d = 1'b0;
          if (len_i == '0) begin
            acc_d   = '0;
            cnt_d   = '0;
            drop_d  = prod_vld_i;
            state_d = S_DONE;
          end else if (prod_vld_i) begin
            acc_d   = sum_res;
            ovf_d   = sum_ovf;
            cnt_d   = len_i - CNT_WIDTH'(1);
            state_d = (len_i == CNT_WIDTH'(1)) ? S_DONE : S_ACC;
          end else begin
            acc_d   = '0;
            cnt_d   = len_i;
            state_d = S_ACC;
          end
        end else begin
          drop_d = prod_vld_i;
        end
      end
      S_ACC: begin
        if (prod_vld_i) begin
          acc_d = sum_res;
          ovf_d = ovf_q | sum_ovf;
          cnt_d = cnt_q - CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        drop_d = prod_vld_i;
        if (res_rdy_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  // Result handshake: res_o/ovf_o are held while res_vld_o=1 and are consumed
  // on the cycle where res_vld_o and res_rdy_i are both high.
  assign acc_rdy_o   = (state_q != S_DONE);
  assign res_vld_o   = (state_q == S_DONE);
  assign res_o       = acc_q;
  assign ovf_o       = ovf_q;
  assign drop_err_o  = drop_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mul_i16_acc.sv
// Bench for mul_i16_acc: four instances (40/33-bit, saturating/wrapping) share
// one stimulus stream and are checked against an integer-arithmetic model.
module tb_mul_i16_acc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        sgn = 1'b0;
  logic        prod_vld = 1'b0;
  logic [31:0] prod = '0;
  logic        res_rdy = 1'b0;

  logic [3:0]  acc_rdy, res_vld, ovf, drop;
  logic [1:0]  dbg [4];
  logic [39:0] res0, res1;
  logic [32:0] res2, res3;

  int checks = 0;
  int failures = 0;
  int aw_p [4] = '{40, 40, 33, 33};
  bit sat_p[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [63:0] exp_q[$];

  mul_i16_acc u_d0 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .len_i(len), .signed_i(sgn),
    .prod_vld_i(prod_vld), .prod_i(prod), .acc_rdy_o(acc_rdy[0]), .res_vld_o(res_vld[0]),
    .res_rdy_i(res_rdy), .res_o(res0), .ovf_o(ovf[0]), .drop_err_o(drop[0]), .dbg_state_o(dbg[0]));
  mul_i16_acc #(.SAT_EN(1'b0)) u_d1 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .len_i(len), .signed_i(sgn),
    .prod_vld_i(prod_vld), .prod_i(prod), .acc_rdy_o(acc_rdy[1]), .res_vld_o(res_vld[1]),
    .res_rdy_i(res_rdy), .res_o(res1), .ovf_o(ovf[1]), .drop_err_o(drop[1]), .dbg_state_o(dbg[1]));
  mul_i16_acc #(.ACC_WIDTH(33)) u_d2 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .len_i(len), .signed_i(sgn),
    .prod_vld_i(prod_vld), .prod_i(prod), .acc_rdy_o(acc_rdy[2]), .res_vld_o(res_vld[2]),
    .res_rdy_i(res_rdy), .res_o(res2), .ovf_o(ovf[2]), .drop_err_o(drop[2]), .dbg_state_o(dbg[2]));
  mul_i16_acc #(.ACC_WIDTH(33), .SAT_EN(1'b0)) u_d3 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .len_i(len), .signed_i(sgn),
    .prod_vld_i(prod_vld), .prod_i(prod), .acc_rdy_o(acc_rdy[3]), .res_vld_o(res_vld[3]),
    .res_rdy_i(res_rdy), .res_o(res3), .ovf_o(ovf[3]), .drop_err_o(drop[3]), .dbg_state_o(dbg[3]));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] get_res(input int i);
    case (i)
      0:       return 64'(res0);
      1:       return 64'(res1);
      2:       return 64'(res2);
      default: return 64'(res3);
    endcase
  endfunction

  // ---------------- reference model ----------------
  // Mathematical running sum with range check after each product.
  function automatic void model_sum(input int aw, input bit sat, input bit s,
                                    input logic [31:0] pq[$],
                                    output logic [63:0] r, output bit o);
    longint m, hi, lo, acc, v, t;
    m = longint'(1) << aw;
    if (s) begin
      hi = m / 2 - 1;
      lo = -(m / 2);
    end else begin
      hi = m - 1;
      lo = 0;
    end
    acc = 0;
    o = 1'b0;
    foreach (pq[k]) begin
      v = s ? longint'($signed(pq[k])) : longint'({32'd0, pq[k]});
      t = acc + v;
      if (t > hi || t < lo) begin
        o = 1'b1;
        if (sat) begin
          acc = (t > hi) ? hi : lo;
        end else begin
          t = t % m;
          if (t < 0) t = t + m;
          if (t > hi) t = t - m;
          acc = t;
        end
      end else begin
        acc = t;
      end
    end
    r = 64'(acc) & 64'(m - 1);
  endfunction

  // ---------------- driver ----------------
  task automatic drive_burst(input bit s, input logic [31:0] pq[$], input bit same,
                             input int gap_max);
    int n;
    n = pq.size();
    start = 1'b1;
    len = 8'(n);
    sgn = s;
    if (same && n > 0) begin
      prod_vld = 1'b1;
      prod = pq[0];
    end else begin
      prod_vld = 1'b0;
    end
    step();
    for (int k = (same && n > 0) ? 1 : 0; k < n; k++) begin
      repeat ($urandom_range(gap_max, 0)) begin
        prod_vld = 1'b0;
        start = 1'($urandom_range(1, 0));
        len = 8'($urandom);
        step();
      end
      start = 1'($urandom_range(1, 0));
      len = 8'($urandom);
      prod_vld = 1'b1;
      prod = pq[k];
      step();
    end
    prod_vld = 1'b0;
    start = 1'b0;
  endtask

  task automatic handshake();
    res_rdy = 1'b1;
    step();
    res_rdy = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({acc_rdy[i], res_vld[i], ovf[i], drop[i]} !== 4'b1000 || get_res(i) !== 64'd0 ||
          dbg[i] !== 2'd0) begin
        failures++;
        $display("FAIL reset inst%0d: rdy/vld/ovf/drop=%b res=%h state=%0d, expected 1000 res=0 state=0",
                 i, {acc_rdy[i], res_vld[i], ovf[i], drop[i]}, get_res(i), dbg[i]);
      end
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_signed_small();
    logic [31:0] pq[$];
    logic [63:0] e;
    bit eo;
    pq = '{32'hFFFF_FFFA, 32'd100, 32'hFFFF_FFFF};
    drive_burst(1'b1, pq, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      model_sum(aw_p[i], sat_p[i], 1'b1, pq, e, eo);
      checks++;
      if (res_vld[i] !== 1'b1 || get_res(i) !== e || ovf[i] !== eo) begin
        failures++;
        $display("FAIL signed_small inst%0d: vld=%b res=%h ovf=%b, expected vld=1 res=%h ovf=%b",
                 i, res_vld[i], get_res(i), ovf[i], e, eo);
      end
    end
    checks++;
    if (res0 !== 40'd93) begin
      failures++;
      $display("FAIL signed_small_93: res=%0d expected 93", res0);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (res_vld[0] !== 1'b1 || res0 !== 40'd93 || acc_rdy[0] !== 1'b0) begin
        failures++;
        $display("FAIL hold cycle%0d: vld=%b res=%0d rdy=%b, expected vld=1 res=93 rdy=0",
                 c, res_vld[0], res0, acc_rdy[0]);
      end
    end
    handshake();
    checks++;
    if (res_vld !== 4'b0000 || acc_rdy !== 4'b1111) begin
      failures++;
      $display("FAIL release: vld=%b rdy=%b, expected vld=0000 rdy=1111", res_vld, acc_rdy);
    end
  endtask

  task automatic test_unsigned_long();
    logic [31:0] pq[$];
    logic [63:0] e;
    bit eo;
    for (int k = 0; k < 255; k++) pq.push_back(32'hFFFF_FFFF);
    drive_burst(1'b0, pq, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      model_sum(aw_p[i], sat_p[i], 1'b0, pq, e, eo);
      checks++;
      if (res_vld[i] !== 1'b1 || get_res(i) !== e || ovf[i] !== eo) begin
        failures++;
        $display("FAIL unsigned_255 inst%0d: vld=%b res=%h ovf=%b, expected vld=1 res=%h ovf=%b",
                 i, res_vld[i], get_res(i), ovf[i], e, eo);
      end
    end
    checks++;
    if (res0 !== 40'hFE_FFFF_FF01 || ovf[0] !== 1'b0 || res2 !== 33'h1_FFFF_FFFF || ovf[2] !== 1'b1) begin
      failures++;
      $display("FAIL unsigned_255_const: res40=%h ovf40=%b res33=%h ovf33=%b, expected fe_ffff_ff01/0 1_ffff_ffff/1",
               res0, ovf[0], res2, ovf[2]);
    end
    handshake();
  endtask

  task automatic test_signed_min();
    logic [31:0] pq[$];
    logic [63:0] e;
    bit eo;
    for (int n = 2; n <= 3; n++) begin
      pq.delete();
      for (int k = 0; k < n; k++) pq.push_back(32'h8000_0000);
      drive_burst(1'b1, pq, 1'b1, 1);
      for (int i = 0; i < 4; i++) begin
        model_sum(aw_p[i], sat_p[i], 1'b1, pq, e, eo);
        checks++;
        if (res_vld[i] !== 1'b1 || get_res(i) !== e || ovf[i] !== eo) begin
          failures++;
          $display("FAIL signed_min len%0d inst%0d: res=%h ovf=%b, expected res=%h ovf=%b",
                   n, i, get_res(i), ovf[i], e, eo);
        end
      end
      if (n == 2) begin
        checks++;
        if (res0 !== 40'hFF_0000_0000 || ovf[0] !== 1'b0) begin
          failures++;
          $display("FAIL signed_min_const: res=%h ovf=%b, expected ff00000000/0", res0, ovf[0]);
        end
      end else begin
        checks++;
        if (res2 !== 33'h1_0000_0000 || ovf[2] !== 1'b1 || res3 !== 33'h0_8000_0000 || ovf[3] !== 1'b1) begin
          failures++;
          $display("FAIL clamp33: sat=%h/%b wrap=%h/%b, expected 100000000/1 080000000/1",
                   res2, ovf[2], res3, ovf[3]);
        end
      end
      handshake();
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] pq[$];
    pq = '{32'd7};
    drive_burst(1'b0, pq, 1'b1, 0);
    checks++;
    if (res_vld !== 4'b1111 || res0 !== 40'd7 || res3 !== 33'd7 || ovf !== 4'b0000) begin
      failures++;
      $display("FAIL len1_same: vld=%b res=%0d ovf=%b, expected vld=1111 res=7 ovf=0", res_vld, res0, ovf);
    end
    handshake();
    pq.delete();
    drive_burst(1'b1, pq, 1'b0, 0);
    checks++;
    if (res_vld !== 4'b1111 || res0 !== 40'd0 || res2 !== 33'd0 || ovf !== 4'b0000) begin
      failures++;
      $display("FAIL len0: vld=%b res=%0d ovf=%b, expected vld=1111 res=0 ovf=0", res_vld, res0, ovf);
    end
    handshake();
  endtask

  task automatic test_drop();
    logic [31:0] pq[$];
    logic [63:0] e;
    bit eo;
    pq = '{$urandom, $urandom};
    model_sum(40, 1'b1, 1'b0, pq, e, eo);
    drive_burst(1'b0, pq, 1'b0, 0);
    prod_vld = 1'b1;
    prod = $urandom;
    step();
    prod_vld = 1'b0;
    checks++;
    if (drop !== 4'b1111 || res_vld !== 4'b1111 || 64'(res0) !== e) begin
      failures++;
      $display("FAIL drop_done: drop=%b vld=%b res=%h, expected drop=1111 vld=1111 res=%h",
               drop, res_vld, res0, e);
    end
    step();
    checks++;
    if (drop !== 4'b0000 || 64'(res0) !== e) begin
      failures++;
      $display("FAIL drop_done_pulse: drop=%b res=%h, expected drop=0000 res=%h", drop, res0, e);
    end
    handshake();
    prod_vld = 1'b1;
    prod = $urandom;
    step();
    prod_vld = 1'b0;
    checks++;
    if (drop !== 4'b1111 || dbg[0] !== 2'd0 || acc_rdy !== 4'b1111 || 64'(res0) !== e) begin
      failures++;
      $display("FAIL drop_idle: drop=%b state=%0d rdy=%b res=%h, expected drop=1111 state=0 rdy=1111 res=%h",
               drop, dbg[0], acc_rdy, res0, e);
    end
    step();
    checks++;
    if (drop !== 4'b0000 || dbg[0] !== 2'd0) begin
      failures++;
      $display("FAIL drop_idle_pulse: drop=%b state=%0d, expected drop=0000 state=0", drop, dbg[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] pq[$];
    start = 1'b1;
    len = 8'd4;
    sgn = 1'b0;
    step();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      prod_vld = 1'b1;
      prod = 32'd1000 + 32'(k);
      step();
    end
    prod_vld = 1'b0;
    rst_n = 1'b0;
    #2;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({acc_rdy[i], res_vld[i], ovf[i], drop[i]} !== 4'b1000 || get_res(i) !== 64'd0 ||
          dbg[i] !== 2'd0) begin
        failures++;
        $display("FAIL reset_mid inst%0d: rdy/vld/ovf/drop=%b res=%h state=%0d, expected 1000 res=0 state=0",
                 i, {acc_rdy[i], res_vld[i], ovf[i], drop[i]}, get_res(i), dbg[i]);
      end
    end
    #1;
    rst_n = 1'b1;
    step();
    pq = '{32'd5};
    drive_burst(1'b0, pq, 1'b1, 0);
    checks++;
    if (res_vld !== 4'b1111 || res0 !== 40'd5 || res2 !== 33'd5) begin
      failures++;
      $display("FAIL after_reset: vld=%b res=%0d, expected vld=1111 res=5", res_vld, res0);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pq[$];
    logic [63:0] e;
    bit eo;
    bit s;
    int n;
    for (int b = 0; b < 30; b++) begin
      n = $urandom_range(12, 1);
      s = 1'($urandom_range(1, 0));
      pq.delete();
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(5, 0))
          0:       pq.push_back(32'hFFFF_FFFF);
          1:       pq.push_back(32'h8000_0000);
          2:       pq.push_back(32'h7FFF_FFFF);
          3:       pq.push_back(32'h0000_0000);
          default: pq.push_back($urandom);
        endcase
      end
      model_sum(40, 1'b1, s, pq, e, eo);
      exp_q.push_back(e);
      checks++;
      if (acc_rdy !== 4'b1111) begin
        failures++;
        $display("FAIL b2b_ready burst%0d: rdy=%b, expected 1111", b, acc_rdy);
      end
      res_rdy = 1'($urandom_range(1, 0));
      drive_burst(s, pq, 1'($urandom_range(1, 0)), 2);
      for (int i = 0; i < 4; i++) begin
        model_sum(aw_p[i], sat_p[i], s, pq, e, eo);
        checks++;
        if (res_vld[i] !== 1'b1 || get_res(i) !== e || ovf[i] !== eo) begin
          failures++;
          $display("FAIL b2b burst%0d inst%0d: vld=%b res=%h ovf=%b, expected vld=1 res=%h ovf=%b",
                   b, i, res_vld[i], get_res(i), ovf[i], e, eo);
        end
      end
      e = exp_q.pop_front();
      checks++;
      if (64'(res0) !== e) begin
        failures++;
        $display("FAIL b2b_scoreboard burst%0d: res=%h expected %h", b, res0, e);
      end
      handshake();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_signed_small();
    test_unsigned_long();
    test_signed_min();
    test_same_cycle();
    test_drop();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
